fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 11 +
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue_mem.sv | 25 ++
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue constants: default widths and the NOP encoding that decode
// also uses when nothing is presented.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEF_XLEN  = 32;
    localparam int unsigned FQ_DEF_DEPTH = 4;

    // addi x0, x0, 0
    localparam logic [31:0] FQ_NOP = 32'h0000_0013;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// Fetch -> queue -> decode handshake bundle. The slave view belongs to the
// queue; the master view belongs to the pipeline around it.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned XLEN = FQ_DEF_XLEN
);

    logic            if_valid_in;
    logic [XLEN-1:0] if_ins_in;
    logic [XLEN-1:0] if_pc_plus_4_in;
    logic            if_ready_out;

    logic            id_valid_out;
    logic [XLEN-1:0] id_ins_out;
    logic [XLEN-1:0] id_pc_plus_4_out;
    logic            id_ready_in;

    modport slave (
        input  if_valid_in, if_ins_in, if_pc_plus_4_in, id_ready_in,
        output if_ready_out, id_valid_out, id_ins_out, id_pc_plus_4_out
    );

    modport master (
        output if_valid_in, if_ins_in, if_pc_plus_4_in, id_ready_in,
        input  if_ready_out, id_valid_out, id_ins_out, id_pc_plus_4_out
    );

endinterface : fetch_queue_if

// File: rtl/fetch_queue_mem.sv
// Entry storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module fetch_queue_mem #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Show-ahead instruction queue between fetch and decode: pointer, occupancy
// and handshake control around the fetch_queue_mem storage.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned XLEN     = FQ_DEF_XLEN,
    parameter int unsigned DEPTH    = FQ_DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_queue_if.slave           bus,
    input  logic                   flush_in,
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   almost_full_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * XLEN;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_rdata;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Full refuses a push even when a pop happens in the same cycle, which keeps
    // if_ready_out free of any path from id_ready_in.
    assign w_push = bus.if_valid_in && !w_full && !flush_in;
    assign w_pop  = !w_empty && bus.id_ready_in && !flush_in;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fetch_queue_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata ({bus.if_ins_in, bus.if_pc_plus_4_in}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // Head entry straight from storage; NOP/0 masks stale contents when empty.
    assign bus.if_ready_out     = !w_full;
    assign bus.id_valid_out     = !w_empty;
    assign bus.id_ins_out       = w_empty ? XLEN'(FQ_NOP) : w_rdata[EW-1:XLEN];
    assign bus.id_pc_plus_4_out = w_empty ? '0 : w_rdata[XLEN-1:0];

    assign count_out       = r_count;
    assign almost_full_out = (r_count >= CW'(AF_LEVEL));

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (XLEN=32, DEPTH=4, AF_LEVEL=3): one task per
// scenario, expected values hand-computed.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic       clk;
    logic       rst_n;
    logic       flush_in;
    logic [2:0] count_out;
    logic       almost_full_out;

    int unsigned passed;
    int unsigned total;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .AF_LEVEL (DEPTH - 1)
    ) dut (
        .clk             (clk),
        .rst             (rst_n),
        .bus             (bus),
        .flush_in        (flush_in),
        .count_out       (count_out),
        .almost_full_out (almost_full_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one cycle, then land 1ns after the rising edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        bus.if_valid_in     = v;
        bus.if_ins_in       = ins;
        bus.if_pc_plus_4_in = pc;
        bus.id_ready_in     = rdy;
        flush_in            = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_valid_in = 1'b0;
        bus.id_ready_in = 1'b0;
        flush_in        = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.if_ready_out !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.if_ready_out); else passed++;
        total++; if (bus.id_valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.id_valid_out); else passed++;
        total++; if (bus.id_ins_out !== NOP) $display("FAIL reset_ins got=%h exp=%h", bus.id_ins_out, NOP); else passed++;
        total++; if (bus.id_pc_plus_4_out !== 32'h0) $display("FAIL reset_pc got=%h exp=0", bus.id_pc_plus_4_out); else passed++;
        total++; if (count_out !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_out); else passed++;
        total++; if (almost_full_out !== 1'b0) $display("FAIL reset_af got=%b exp=0", almost_full_out); else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_first_push();
        drive(1'b1, 32'h0050_0093, 32'h4, 1'b0, 1'b0);
        idle();
        total++; if (bus.id_valid_out !== 1'b1) $display("FAIL push_valid got=%b exp=1", bus.id_valid_out); else passed++;
        total++; if (bus.id_ins_out !== 32'h0050_0093) $display("FAIL push_ins got=%h exp=00500093", bus.id_ins_out); else passed++;
        total++; if (bus.id_pc_plus_4_out !== 32'h4) $display("FAIL push_pc got=%h exp=4", bus.id_pc_plus_4_out); else passed++;
        total++; if (count_out !== 3'd1) $display("FAIL push_count got=%0d exp=1", count_out); else passed++;
    endtask

    task automatic test_fill_overflow();
        int unsigned exp_cnt;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
            exp_cnt = (i < 4) ? i + 1 : 4;
            total++; if (count_out !== 3'(exp_cnt)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_out, exp_cnt); else passed++;
            total++; if (bus.if_ready_out !== (exp_cnt != 4)) $display("FAIL fill_ready[%0d] got=%b exp=%b", i, bus.if_ready_out, exp_cnt != 4); else passed++;
            total++; if (almost_full_out !== (exp_cnt >= 3)) $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full_out, exp_cnt >= 3); else passed++;
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.id_ins_out !== 32'h100 + 32'(i)) $display("FAIL drain_ins[%0d] got=%h exp=%h", i, bus.id_ins_out, 32'h100 + 32'(i)); else passed++;
            total++; if (bus.id_pc_plus_4_out !== 32'h1000 + 32'(4 * i)) $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.id_pc_plus_4_out, 32'h1000 + 32'(4 * i)); else passed++;
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        idle();
        total++; if (bus.id_valid_out !== 1'b0) $display("FAIL fifth_not_stored valid got=%b exp=0", bus.id_valid_out); else passed++;
        total++; if (bus.id_ins_out !== NOP) $display("FAIL empty_ins got=%h exp=%h", bus.id_ins_out, NOP); else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h200 + 32'(i), 32'h2000 + 32'(i), 1'b0, 1'b0);
        total++; if (count_out !== 3'd4) $display("FAIL fpp_full got=%0d exp=4", count_out); else passed++;
        drive(1'b1, 32'h204, 32'h2004, 1'b1, 1'b0);
        total++; if (count_out !== 3'd3) $display("FAIL fpp_pop_only got=%0d exp=3", count_out); else passed++;
        total++; if (bus.id_ins_out !== 32'h201) $display("FAIL fpp_head got=%h exp=201", bus.id_ins_out); else passed++;
        drive(1'b1, 32'h204, 32'h2004, 1'b0, 1'b0);
        total++; if (count_out !== 3'd4) $display("FAIL fpp_refill got=%0d exp=4", count_out); else passed++;
        idle();
        for (int i = 1; i < 5; i++) begin
            total++; if (bus.id_ins_out !== 32'h200 + 32'(i)) $display("FAIL fpp_order[%0d] got=%h exp=%h", i, bus.id_ins_out, 32'h200 + 32'(i)); else passed++;
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        idle();
        total++; if (count_out !== 3'd0) $display("FAIL fpp_empty got=%0d exp=0", count_out); else passed++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h300, 32'h3000, 1'b0, 1'b0);
        drive(1'b1, 32'h301, 32'h3004, 1'b0, 1'b0);
        total++; if (count_out !== 3'd2) $display("FAIL flush_pre got=%0d exp=2", count_out); else passed++;
        drive(1'b1, 32'h302, 32'h3008, 1'b1, 1'b1);
        idle();
        total++; if (count_out !== 3'd0) $display("FAIL flush_count got=%0d exp=0", count_out); else passed++;
        total++; if (bus.id_valid_out !== 1'b0) $display("FAIL flush_valid got=%b exp=0", bus.id_valid_out); else passed++;
        total++; if (bus.id_ins_out !== NOP) $display("FAIL flush_ins got=%h exp=%h", bus.id_ins_out, NOP); else passed++;
        total++; if (bus.id_pc_plus_4_out !== 32'h0) $display("FAIL flush_pc got=%h exp=0", bus.id_pc_plus_4_out); else passed++;
        // After the flush the pointers are 0: the next push must be the new head.
        drive(1'b1, 32'h3AA, 32'h30AA, 1'b0, 1'b0);
        idle();
        total++; if (bus.id_ins_out !== 32'h3AA) $display("FAIL flush_restart got=%h exp=3aa", bus.id_ins_out); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_stream();
        drive(1'b1, 32'h400, 32'h4004, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            total++; if (bus.id_ins_out !== 32'h400 + 32'(i - 1)) $display("FAIL stream_ins[%0d] got=%h exp=%h", i - 1, bus.id_ins_out, 32'h400 + 32'(i - 1)); else passed++;
            total++; if (bus.id_pc_plus_4_out !== 32'h4004 + 32'(4 * (i - 1))) $display("FAIL stream_pc[%0d] got=%h exp=%h", i - 1, bus.id_pc_plus_4_out, 32'h4004 + 32'(4 * (i - 1))); else passed++;
            if (i < 10) begin
                drive(1'b1, 32'h400 + 32'(i), 32'h4004 + 32'(4 * i), 1'b1, 1'b0);
                total++; if (count_out !== 3'd1) $display("FAIL stream_count[%0d] got=%0d exp=1", i, count_out); else passed++;
            end else begin
                drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            end
        end
        idle();
        total++; if (count_out !== 3'd0) $display("FAIL stream_end got=%0d exp=0", count_out); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(i), 32'h5000 + 32'(i), 1'b0, 1'b0);
        idle();
        total++; if (count_out !== 3'd3) $display("FAIL arst_pre got=%0d exp=3", count_out); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (count_out !== 3'd0) $display("FAIL arst_count got=%0d exp=0", count_out); else passed++;
        total++; if (bus.id_valid_out !== 1'b0) $display("FAIL arst_valid got=%b exp=0", bus.id_valid_out); else passed++;
        total++; if (bus.id_ins_out !== NOP) $display("FAIL arst_ins got=%h exp=%h", bus.id_ins_out, NOP); else passed++;
        total++; if (bus.id_pc_plus_4_out !== 32'h0) $display("FAIL arst_pc got=%h exp=0", bus.id_pc_plus_4_out); else passed++;
        total++; if (almost_full_out !== 1'b0) $display("FAIL arst_af got=%b exp=0", almost_full_out); else passed++;
        total++; if (bus.if_ready_out !== 1'b1) $display("FAIL arst_ready got=%b exp=1", bus.if_ready_out); else passed++;
        // Release between edges with a push pending: it must land on the next edge.
        bus.if_valid_in     = 1'b1;
        bus.if_ins_in       = 32'h600;
        bus.if_pc_plus_4_in = 32'h6004;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        total++; if (count_out !== 3'd1) $display("FAIL arst_first_push got=%0d exp=1", count_out); else passed++;
        total++; if (bus.id_ins_out !== 32'h600) $display("FAIL arst_first_ins got=%h exp=600", bus.id_ins_out); else passed++;
    endtask

    initial begin
        passed              = 0;
        total               = 0;
        rst_n               = 1'b0;
        flush_in            = 1'b0;
        bus.if_valid_in     = 1'b0;
        bus.if_ins_in       = '0;
        bus.if_pc_plus_4_in = '0;
        bus.id_ready_in     = 1'b0;

        test_reset();
        test_first_push();
        test_fill_overflow();
        test_full_push_pop();
        test_flush();
        test_stream();
        test_async_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_fetch_queue
